// File: rtl/alu_misc_pkg.sv
// Shared encodings, default sizes and flag bundle for the miscellaneous
// integer functional unit (ALU + shifter with a delay pipeline).
package alu_misc_pkg;

    localparam int AM_DEF_WIDTH  = 32;
    localparam int AM_DEF_STAGES = 4;
    localparam int AM_DEF_REGW   = 5;

    typedef enum logic [2:0] {
        ALU_ADD   = 3'b000,
        ALU_SUB   = 3'b001,
        ALU_AND   = 3'b010,
        ALU_OR    = 3'b011,
        ALU_XOR   = 3'b100,
        ALU_NOR   = 3'b101,
        ALU_SLT   = 3'b110,
        ALU_PASSB = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        SH_SLL  = 2'b00,
        SH_SRL  = 2'b01,
        SH_SRA  = 2'b10,
        SH_PASS = 2'b11
    } shift_op_e;

    // Width-independent part of a result payload; the top wraps this together
    // with the parametrised regdest and value fields.
    typedef struct packed {
        logic writereg;
        logic overflow;
    } am_flags_t;

endpackage

// File: rtl/alu_misc_exec.sv
// Issue-stage datapath: operand B mux, ALU, shifter, signed overflow
// detection and the overflow-gated register write enable. Purely combinational.
import alu_misc_pkg::*;

module alu_misc_exec #(
    parameter int WIDTH = AM_DEF_WIDTH
) (
    input  logic                     sel_alu_shift,
    input  logic                     sel_imm_b,
    input  logic [2:0]               alu_op,
    input  logic                     unsig,
    input  logic [1:0]               shift_op,
    input  logic [$clog2(WIDTH)-1:0] shift_amt,
    input  logic [WIDTH-1:0]         rega,
    input  logic [WIDTH-1:0]         regb,
    input  logic [WIDTH-1:0]         imedext,
    input  logic                     writereg,
    input  logic                     writeov,
    output logic [WIDTH-1:0]         value,
    output am_flags_t                flags
);

    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] alu_res;
    logic [WIDTH-1:0] shift_res;
    logic             alu_ov;
    logic             less;

    // ALU: overflow uses the sign rule on the top bit and is only meaningful for signed ADD/SUB.
    always_comb begin
        op_b    = sel_imm_b ? imedext : regb;
        sum     = rega + op_b;
        diff    = rega - op_b;
        less    = unsig ? (rega < op_b) : ($signed(rega) < $signed(op_b));
        alu_res = '0;
        alu_ov  = 1'b0;
        case (alu_op_e'(alu_op))
            ALU_ADD: begin
                alu_res = sum;
                alu_ov  = ~unsig & (rega[WIDTH-1] == op_b[WIDTH-1]) & (sum[WIDTH-1] != rega[WIDTH-1]);
            end
            ALU_SUB: begin
                alu_res = diff;
                alu_ov  = ~unsig & (rega[WIDTH-1] != op_b[WIDTH-1]) & (diff[WIDTH-1] != rega[WIDTH-1]);
            end
            ALU_AND:   alu_res = rega & op_b;
            ALU_OR:    alu_res = rega | op_b;
            ALU_XOR:   alu_res = rega ^ op_b;
            ALU_NOR:   alu_res = ~(rega | op_b);
            ALU_SLT:   alu_res = {{(WIDTH-1){1'b0}}, less};
            ALU_PASSB: alu_res = op_b;
        endcase
    end

    // Shifter always works on regb, never on the immediate.
    always_comb begin
        shift_res = regb;
        case (shift_op_e'(shift_op))
            SH_SLL:  shift_res = regb << shift_amt;
            SH_SRL:  shift_res = regb >> shift_amt;
            SH_SRA:  shift_res = WIDTH'($signed(regb) >>> shift_amt);
            SH_PASS: shift_res = regb;
        endcase
    end

    // Result select; an overflowing op only writes back when the issuer asked for it.
    always_comb begin
        value          = sel_alu_shift ? shift_res : alu_res;
        flags.overflow = ~sel_alu_shift & alu_ov;
        flags.writereg = writereg & (~flags.overflow | writeov);
    end

endmodule

// File: rtl/alu_misc_pipe.sv
// Miscellaneous integer unit: computes in the issue cycle, then carries the
// result through STAGES register slices to writeback with stall and flush.
import alu_misc_pkg::*;

module alu_misc_pipe #(
    parameter int WIDTH  = AM_DEF_WIDTH,
    parameter int STAGES = AM_DEF_STAGES,
    parameter int REGW   = AM_DEF_REGW
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     iss_am_oper,
    input  logic                     iss_am_selalushift,
    input  logic                     iss_am_selimregb,
    input  logic [2:0]               iss_am_aluop,
    input  logic                     iss_am_unsig,
    input  logic [1:0]               iss_am_shiftop,
    input  logic [$clog2(WIDTH)-1:0] iss_am_shiftamt,
    input  logic [WIDTH-1:0]         iss_am_rega,
    input  logic [WIDTH-1:0]         iss_am_regb,
    input  logic [WIDTH-1:0]         iss_am_imedext,
    input  logic [REGW-1:0]          iss_am_regdest,
    input  logic                     iss_am_writereg,
    input  logic                     iss_am_writeov,
    input  logic                     wb_am_stall,
    input  logic                     am_flush,
    output logic                     am_iss_ready,
    output logic                     am_wb_oper,
    output logic [REGW-1:0]          am_wb_regdest,
    output logic                     am_wb_writereg,
    output logic [WIDTH-1:0]         am_wb_wbvalue,
    output logic                     am_wb_overflow,
    output logic                     am_busy
);

    typedef struct packed {
        logic [REGW-1:0]  regdest;
        am_flags_t        flags;
        logic [WIDTH-1:0] value;
    } payload_t;

    logic [WIDTH-1:0] exec_value;
    am_flags_t        exec_flags;
    payload_t         issue_payload;

    logic             slice_in_valid [STAGES];
    payload_t         slice_in       [STAGES];
    logic             valid_q        [STAGES];
    payload_t         slice_q        [STAGES];

    alu_misc_exec #(.WIDTH(WIDTH)) u_exec (
        .sel_alu_shift (iss_am_selalushift),
        .sel_imm_b     (iss_am_selimregb),
        .alu_op        (iss_am_aluop),
        .unsig         (iss_am_unsig),
        .shift_op      (iss_am_shiftop),
        .shift_amt     (iss_am_shiftamt),
        .rega          (iss_am_rega),
        .regb          (iss_am_regb),
        .imedext       (iss_am_imedext),
        .writereg      (iss_am_writereg),
        .writeov       (iss_am_writeov),
        .value         (exec_value),
        .flags         (exec_flags)
    );

    assign issue_payload = '{regdest: iss_am_regdest, flags: exec_flags, value: exec_value};

    // Slice 0 takes a zero payload when nothing issues so bubbles never carry stale data.
    assign slice_in_valid[0] = iss_am_oper;
    assign slice_in[0]       = iss_am_oper ? issue_payload : '0;

    for (genvar g = 0; g < STAGES; g++) begin : g_slice
        if (g > 0) begin : g_link
            assign slice_in_valid[g] = valid_q[g-1];
            assign slice_in[g]       = slice_q[g-1];
        end

        // Each slice clears on reset or flush, freezes on stall, otherwise takes its upstream neighbour.
        always_ff @(posedge clock) begin
            if (reset || am_flush) begin
                valid_q[g] <= 1'b0;
                slice_q[g] <= '0;
            end else if (!wb_am_stall) begin
                valid_q[g] <= slice_in_valid[g];
                slice_q[g] <= slice_in[g];
            end
        end
    end

    // Busy whenever any slice still carries an op.
    always_comb begin
        am_busy = 1'b0;
        for (int i = 0; i < STAGES; i++) begin
            am_busy = am_busy | valid_q[i];
        end
    end

    assign am_iss_ready   = ~wb_am_stall;
    assign am_wb_oper     = valid_q[STAGES-1];
    assign am_wb_regdest  = slice_q[STAGES-1].regdest;
    assign am_wb_writereg = slice_q[STAGES-1].flags.writereg;
    assign am_wb_overflow = slice_q[STAGES-1].flags.overflow;
    assign am_wb_wbvalue  = slice_q[STAGES-1].value;

endmodule
